// File: rtl/fc_control_tiled.sv
// Sequencer for a tiled fully-connected layer: loads the input feature map once,
// then runs one read pass over it per output tile and hands each tile result downstream.
module fc_control_tiled #(
    parameter int IFM_SIZE = 9162,
    parameter int OFM_SIZE = 4096,
    parameter int TILE     = 8,
    parameter int RD_LAT   = 2,
    parameter int AW       = 14,
    parameter int TW       = 10
) (
    input  logic            clk1,
    input  logic            rst,
    input  logic            start,
    input  logic            relu_en,
    input  logic            ifm_valid,
    output logic            ifm_ready,
    output logic            ifm_wr_en,
    output logic [AW-1:0]   ifm_wr_addr,
    output logic            rd_en,
    output logic [AW-1:0]   rd_addr,
    output logic            acc_clr,
    output logic            acc_en,
    output logic            ofm_valid,
    input  logic            ofm_ready,
    output logic [TW-1:0]   ofm_tile,
    output logic [TILE-1:0] lane_mask,
    output logic            relu_out,
    output logic            busy,
    output logic            done
);

    localparam int NT  = (OFM_SIZE + TILE - 1) / TILE;
    localparam int REM = OFM_SIZE % TILE;

    localparam logic [AW-1:0] LAST_ADDR  = AW'(IFM_SIZE - 1);
    localparam logic [TW-1:0] LAST_TILE  = TW'(NT - 1);
    localparam logic [2:0]    LAST_DRAIN = 3'(RD_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COMPUTE,
        S_DRAIN,
        S_OUT,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   load_cnt_q, load_cnt_d;
    logic [AW-1:0]   rd_cnt_q, rd_cnt_d;
    logic [2:0]      drain_cnt_q, drain_cnt_d;
    logic [TW-1:0]   tile_q, tile_d;
    logic            relu_q, relu_d;
    logic            ifm_ready_q, ifm_ready_d;
    logic            rd_en_q, rd_en_d;
    logic            acc_clr_q, acc_clr_d;
    logic            ofm_valid_q, ofm_valid_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;
    logic [TILE-1:0] lane_mask_q, lane_mask_d;
    logic [RD_LAT-1:0] acc_sr_q, acc_sr_d;

    // Only the final tile can be partial, and only when TILE does not divide OFM_SIZE.
    function automatic logic [TILE-1:0] mask_for(input logic [TW-1:0] t);
        mask_for = '1;
        if (REM != 0 && t == LAST_TILE) begin
            for (int i = REM; i < TILE; i++) mask_for[i] = 1'b0;
        end
    endfunction

    assign ifm_wr_en = ifm_valid & ifm_ready_q;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d     = state_q;
        load_cnt_d  = load_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        drain_cnt_d = drain_cnt_q;
        tile_d      = tile_q;
        relu_d      = relu_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_LOAD;
                    load_cnt_d  = '0;
                    rd_cnt_d    = '0;
                    drain_cnt_d = '0;
                    tile_d      = '0;
                    relu_d      = relu_en;
                end
            end
            S_LOAD: begin
                if (ifm_wr_en) begin
                    if (load_cnt_q == LAST_ADDR) begin
                        load_cnt_d = '0;
                        state_d    = S_COMPUTE;
                    end else begin
                        load_cnt_d = load_cnt_q + 1'b1;
                    end
                end
            end
            S_COMPUTE: begin
                if (rd_cnt_q == LAST_ADDR) begin
                    rd_cnt_d = '0;
                    state_d  = S_DRAIN;
                end else begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (drain_cnt_q == LAST_DRAIN) begin
                    drain_cnt_d = '0;
                    state_d     = S_OUT;
                end else begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                end
            end
            S_OUT: begin
                if (ofm_ready) begin
                    if (tile_q == LAST_TILE) begin
                        state_d = S_DONE;
                    end else begin
                        tile_d  = tile_q + 1'b1;
                        state_d = S_COMPUTE;
                    end
                end
            end
            S_DONE: begin
                tile_d  = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they leave the block registered.
        ifm_ready_d = (state_d == S_LOAD);
        rd_en_d     = (state_d == S_COMPUTE);
        acc_clr_d   = (state_d == S_COMPUTE) && (rd_cnt_d == '0);
        ofm_valid_d = (state_d == S_OUT);
        done_d      = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
        lane_mask_d = mask_for(tile_d);
        acc_sr_d    = RD_LAT'({acc_sr_q, rd_en_q});
    end

    always_ff @(posedge clk1) begin
        // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
        if (rst) begin
            state_q     <= S_IDLE;
            load_cnt_q  <= '0;
            rd_cnt_q    <= '0;
            drain_cnt_q <= '0;
            tile_q      <= '0;
            relu_q      <= 1'b0;
            ifm_ready_q <= 1'b0;
            rd_en_q     <= 1'b0;
            acc_clr_q   <= 1'b0;
            ofm_valid_q <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            lane_mask_q <= '1;
            acc_sr_q    <= '0;
        end else begin
            state_q     <= state_d;
            load_cnt_q  <= load_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            tile_q      <= tile_d;
            relu_q      <= relu_d;
            ifm_ready_q <= ifm_ready_d;
            rd_en_q     <= rd_en_d;
            acc_clr_q   <= acc_clr_d;
            ofm_valid_q <= ofm_valid_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            lane_mask_q <= lane_mask_d;
            acc_sr_q    <= acc_sr_d;
        end
    end

    assign ifm_ready   = ifm_ready_q;
    assign ifm_wr_addr = load_cnt_q;
    assign rd_en       = rd_en_q;
    assign rd_addr     = rd_cnt_q;
    assign acc_clr     = acc_clr_q;
    assign acc_en      = acc_sr_q[RD_LAT-1];
    assign ofm_valid   = ofm_valid_q;
    assign ofm_tile    = tile_q;
    assign lane_mask   = lane_mask_q;
    assign relu_out    = relu_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_fc_control_tiled.sv
// Directed bench for fc_control_tiled: a 3-tile layer with a partial last tile (dut)
// and a 2-tile layer with full tiles (dut2), both IFM_SIZE=4, RD_LAT=2.
module tb_fc_control_tiled;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic       rst, start, relu_en, ifm_valid, ofm_ready;
    logic       ifm_ready, ifm_wr_en, rd_en, acc_clr, acc_en, ofm_valid, relu_out, busy, done;
    logic [3:0] ifm_wr_addr, rd_addr, ofm_tile;
    logic [7:0] lane_mask;

    logic       start2, relu_en2, ifm_valid2, ofm_ready2;
    logic       ifm_ready2, ifm_wr_en2, rd_en2, acc_clr2, acc_en2, ofm_valid2, relu_out2, busy2, done2;
    logic [3:0] ifm_wr_addr2, rd_addr2, ofm_tile2;
    logic [7:0] lane_mask2;

    fc_control_tiled #(
        .IFM_SIZE(4), .OFM_SIZE(20), .TILE(8), .RD_LAT(2), .AW(4), .TW(4)
    ) dut (
        .clk1(clk), .rst(rst), .start(start), .relu_en(relu_en),
        .ifm_valid(ifm_valid), .ifm_ready(ifm_ready), .ifm_wr_en(ifm_wr_en),
        .ifm_wr_addr(ifm_wr_addr), .rd_en(rd_en), .rd_addr(rd_addr),
        .acc_clr(acc_clr), .acc_en(acc_en), .ofm_valid(ofm_valid),
        .ofm_ready(ofm_ready), .ofm_tile(ofm_tile), .lane_mask(lane_mask),
        .relu_out(relu_out), .busy(busy), .done(done)
    );

    fc_control_tiled #(
        .IFM_SIZE(4), .OFM_SIZE(16), .TILE(8), .RD_LAT(2), .AW(4), .TW(4)
    ) dut2 (
        .clk1(clk), .rst(rst), .start(start2), .relu_en(relu_en2),
        .ifm_valid(ifm_valid2), .ifm_ready(ifm_ready2), .ifm_wr_en(ifm_wr_en2),
        .ifm_wr_addr(ifm_wr_addr2), .rd_en(rd_en2), .rd_addr(rd_addr2),
        .acc_clr(acc_clr2), .acc_en(acc_en2), .ofm_valid(ofm_valid2),
        .ofm_ready(ofm_ready2), .ofm_tile(ofm_tile2), .lane_mask(lane_mask2),
        .relu_out(relu_out2), .busy(busy2), .done(done2)
    );

    logic [7:0] flags;
    assign flags = {ifm_ready, ifm_wr_en, rd_en, acc_clr, acc_en, ofm_valid, done, busy};

    // Expected {rd_en, acc_clr, acc_en, ofm_valid} at phase ph of a tile pass (ph 0 = first read).
    function automatic logic [3:0] pass_flags(input int ph);
        pass_flags = {(ph >= 0) && (ph <= 3), ph == 0, (ph >= 2) && (ph <= 5), ph == 6};
    endfunction

    task automatic idle_inputs();
        start = 0; relu_en = 0; ifm_valid = 0; ofm_ready = 0;
        start2 = 0; relu_en2 = 0; ifm_valid2 = 0; ofm_ready2 = 0;
    endtask

    // Leaves the bench just after a negedge with rst released; the next negedge opens cycle 0.
    task automatic do_reset();
        idle_inputs();
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1; start = 1; relu_en = 1; ifm_valid = 1; ofm_ready = 1; start2 = 1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (flags !== 8'h00 || ifm_wr_addr !== 4'd0 || rd_addr !== 4'd0 || ofm_tile !== 4'd0) begin
            errors++;
            $display("FAIL reset_outputs flags=%b wr_addr=%0d rd_addr=%0d tile=%0d required 0", flags, ifm_wr_addr, rd_addr, ofm_tile);
        end
        checks++;
        if (lane_mask !== 8'hFF || relu_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_mask lane_mask=%h relu_out=%b required FF/0", lane_mask, relu_out);
        end
        checks++;
        if (busy2 !== 1'b0 || lane_mask2 !== 8'hFF || ifm_ready2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_dut2 busy=%b lane_mask=%h ifm_ready=%b required 0/FF/0", busy2, lane_mask2, ifm_ready2);
        end
        idle_inputs();
        rst = 0;
    endtask

    task automatic test_load_compute();
        logic [7:0] exp;
        for (int c = 0; c <= 11; c++) begin
            @(negedge clk);
            start = (c == 0); relu_en = 1; ifm_valid = (c >= 1 && c <= 4); ofm_ready = 1;
            #1;
            exp = {c >= 1 && c <= 4, c >= 1 && c <= 4, pass_flags(c - 5), 1'b0, c >= 1};
            checks++;
            if (flags !== exp) begin
                errors++;
                $display("FAIL load_compute c=%0d flags=%b required %b", c, flags, exp);
            end
            if (c >= 1 && c <= 4) begin
                checks++;
                if (ifm_wr_addr !== 4'(c - 1)) begin
                    errors++;
                    $display("FAIL load_addr c=%0d wr_addr=%0d required %0d", c, ifm_wr_addr, c - 1);
                end
            end
            if (c >= 5 && c <= 8) begin
                checks++;
                if (rd_addr !== 4'(c - 5)) begin
                    errors++;
                    $display("FAIL rd_addr c=%0d rd_addr=%0d required %0d", c, rd_addr, c - 5);
                end
            end
            if (c == 1) begin
                checks++;
                if (relu_out !== 1'b1) begin
                    errors++;
                    $display("FAIL relu_latch relu_out=%b required 1", relu_out);
                end
            end
            if (c == 11) begin
                checks++;
                if (ofm_tile !== 4'd0 || lane_mask !== 8'hFF) begin
                    errors++;
                    $display("FAIL tile0_out tile=%0d mask=%h required 0/FF", ofm_tile, lane_mask);
                end
            end
        end
    endtask

    // Continues the layer from test_load_compute with ofm_ready held high.
    task automatic test_tiles();
        logic [7:0] exp;
        int ph, t;
        for (int c = 12; c <= 28; c++) begin
            @(negedge clk);
            start = 0; ifm_valid = 0; ofm_ready = 1;
            #1;
            ph = (c - 5) % 7;
            t  = (c - 5) / 7;
            if (c <= 25)      exp = {2'b00, pass_flags(ph), 1'b0, 1'b1};
            else if (c == 26) exp = 8'b0000_0011;
            else              exp = 8'h00;
            checks++;
            if (flags !== exp) begin
                errors++;
                $display("FAIL tiles c=%0d flags=%b required %b", c, flags, exp);
            end
            if (c <= 25 && ph <= 3) begin
                checks++;
                if (rd_addr !== 4'(ph)) begin
                    errors++;
                    $display("FAIL tiles_rd_addr c=%0d rd_addr=%0d required %0d", c, rd_addr, ph);
                end
            end
            if (c <= 25 && ph == 6) begin
                checks++;
                if (ofm_tile !== 4'(t) || lane_mask !== ((t == 2) ? 8'h0F : 8'hFF)) begin
                    errors++;
                    $display("FAIL tile_out c=%0d tile=%0d mask=%h required %0d/%h", c, ofm_tile, lane_mask, t, (t == 2) ? 8'h0F : 8'hFF);
                end
            end
        end
    endtask

    task automatic test_ifm_gaps();
        logic [6:0] pat;
        logic       exp_wr;
        int         nwr;
        pat = 7'b1011001;
        nwr = 0;
        do_reset();
        for (int c = 0; c <= 9; c++) begin
            @(negedge clk);
            start = (c == 0);
            ifm_valid = (c >= 1 && c <= 7) ? pat[c-1] : (c == 8);
            #1;
            exp_wr = (c >= 1 && c <= 7) ? pat[c-1] : 1'b0;
            checks++;
            if (ifm_wr_en !== exp_wr || ifm_ready !== (c >= 1 && c <= 7)) begin
                errors++;
                $display("FAIL gaps_write c=%0d wr_en=%b ready=%b required %b/%b", c, ifm_wr_en, ifm_ready, exp_wr, c >= 1 && c <= 7);
            end
            if (exp_wr) begin
                checks++;
                if (ifm_wr_addr !== 4'(nwr)) begin
                    errors++;
                    $display("FAIL gaps_addr c=%0d wr_addr=%0d required %0d", c, ifm_wr_addr, nwr);
                end
                nwr++;
            end
            checks++;
            if (rd_en !== (c >= 8) || acc_clr !== (c == 8)) begin
                errors++;
                $display("FAIL gaps_compute c=%0d rd_en=%b acc_clr=%b required %b/%b", c, rd_en, acc_clr, c >= 8, c == 8);
            end
            if (c >= 8) begin
                checks++;
                if (rd_addr !== 4'(c - 8)) begin
                    errors++;
                    $display("FAIL gaps_rd_addr c=%0d rd_addr=%0d required %0d", c, rd_addr, c - 8);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int c = 0; c <= 17; c++) begin
            @(negedge clk);
            start = (c == 0); ifm_valid = (c >= 1 && c <= 4); ofm_ready = (c >= 16);
            #1;
            if (c >= 11 && c <= 16) begin
                checks++;
                if (ofm_valid !== 1'b1 || ofm_tile !== 4'd0 || lane_mask !== 8'hFF || rd_en !== 1'b0) begin
                    errors++;
                    $display("FAIL hold c=%0d valid=%b tile=%0d mask=%h rd_en=%b required 1/0/FF/0", c, ofm_valid, ofm_tile, lane_mask, rd_en);
                end
            end
            if (c == 17) begin
                checks++;
                if (rd_en !== 1'b1 || acc_clr !== 1'b1 || rd_addr !== 4'd0 || ofm_valid !== 1'b0 || ofm_tile !== 4'd1) begin
                    errors++;
                    $display("FAIL release rd_en=%b acc_clr=%b rd_addr=%0d valid=%b tile=%0d required 1/1/0/0/1", rd_en, acc_clr, rd_addr, ofm_valid, ofm_tile);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int c = 0; c <= 13; c++) begin
            @(negedge clk);
            start = (c == 0); relu_en = 1; ifm_valid = (c >= 1 && c <= 4); ofm_ready = 1;
            rst = (c == 13);
            #1;
            if (c == 12) begin
                checks++;
                if (rd_en !== 1'b1 || ofm_tile !== 4'd1 || relu_out !== 1'b1) begin
                    errors++;
                    $display("FAIL mid_pre rd_en=%b tile=%0d relu_out=%b required 1/1/1", rd_en, ofm_tile, relu_out);
                end
            end
        end
        @(negedge clk);
        rst = 0; start = 0; relu_en = 0; ifm_valid = 0;
        #1;
        checks++;
        if (flags !== 8'h00 || ofm_tile !== 4'd0 || lane_mask !== 8'hFF || relu_out !== 1'b0 || rd_addr !== 4'd0 || ifm_wr_addr !== 4'd0) begin
            errors++;
            $display("FAIL mid_reset flags=%b tile=%0d mask=%h relu=%b rd_addr=%0d wr_addr=%0d required reset values", flags, ofm_tile, lane_mask, relu_out, rd_addr, ifm_wr_addr);
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            ifm_valid = 1;
            #1;
            checks++;
            if (flags !== 8'h00) begin
                errors++;
                $display("FAIL mid_idle c=%0d flags=%b required 00000000", c, flags);
            end
        end
        for (int c = 0; c <= 2; c++) begin
            @(negedge clk);
            start = (c == 0); ifm_valid = (c >= 1);
            #1;
            if (c >= 1) begin
                checks++;
                if (ifm_wr_en !== 1'b1 || ifm_wr_addr !== 4'(c - 1)) begin
                    errors++;
                    $display("FAIL mid_reload c=%0d wr_en=%b wr_addr=%0d required 1/%0d", c, ifm_wr_en, ifm_wr_addr, c - 1);
                end
            end
        end
    endtask

    task automatic test_two_tiles();
        do_reset();
        for (int c = 0; c <= 20; c++) begin
            @(negedge clk);
            start2 = (c == 0 || c == 2); relu_en2 = (c == 2);
            ifm_valid2 = (c >= 1 && c <= 4); ofm_ready2 = 1;
            #1;
            if (c >= 1 && c <= 4) begin
                checks++;
                if (ifm_wr_en2 !== 1'b1 || ifm_wr_addr2 !== 4'(c - 1)) begin
                    errors++;
                    $display("FAIL two_load c=%0d wr_en=%b wr_addr=%0d required 1/%0d", c, ifm_wr_en2, ifm_wr_addr2, c - 1);
                end
            end
            if (c == 5 || c == 12) begin
                checks++;
                if (rd_en2 !== 1'b1 || acc_clr2 !== 1'b1 || rd_addr2 !== 4'd0 || relu_out2 !== 1'b0) begin
                    errors++;
                    $display("FAIL two_pass c=%0d rd_en=%b acc_clr=%b rd_addr=%0d relu=%b required 1/1/0/0", c, rd_en2, acc_clr2, rd_addr2, relu_out2);
                end
            end
            if (c == 11 || c == 18) begin
                checks++;
                if (ofm_valid2 !== 1'b1 || ofm_tile2 !== ((c == 11) ? 4'd0 : 4'd1) || lane_mask2 !== 8'hFF) begin
                    errors++;
                    $display("FAIL two_out c=%0d valid=%b tile=%0d mask=%h required 1/%0d/FF", c, ofm_valid2, ofm_tile2, lane_mask2, (c == 11) ? 0 : 1);
                end
            end
            if (c >= 11) begin
                checks++;
                if (done2 !== (c == 19) || busy2 !== (c <= 19)) begin
                    errors++;
                    $display("FAIL two_done c=%0d done=%b busy=%b required %b/%b", c, done2, busy2, c == 19, c <= 19);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_compute();
        test_tiles();
        test_ifm_gaps();
        test_backpressure();
        test_reset_mid();
        test_two_tiles();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fc_control_tiled.md
FC_CONTROL_TILED -- requirements
Module: fc_control_tiled

Interface
REQ-001 SHALL have parameter IFM_SIZE, default 9162, input feature vector length in words.
REQ-002 SHALL have parameter OFM_SIZE, default 4096, output neuron count.
REQ-003 SHALL have parameter TILE, default 8, output neurons computed in parallel per pass.
REQ-004 SHALL have parameter RD_LAT, default 2, buffer/weight read-to-accumulator latency in cycles, legal range 1-7.
REQ-005 SHALL have parameter AW, default 14, address width, sized so that 2^AW >= IFM_SIZE.
REQ-006 SHALL have parameter TW, default 10, tile-index width, sized so that 2^TW >= NT, where NT = ceil(OFM_SIZE/TILE).
REQ-007 clk1  input  1  sole clock; every register updates on its rising edge.
REQ-008 rst  input  1  reset, synchronous and active-high.
REQ-009 start  input  1  one-cycle request to begin a layer; sampled in IDLE only.
REQ-010 relu_en  input  1  mode bit, latched when start is accepted.
REQ-011 ifm_valid  input  1  input-feature word present.
REQ-012 ifm_ready  output  1  block accepts input-feature words.
REQ-013 ifm_wr_en  output  1  IFM buffer write strobe.
REQ-014 ifm_wr_addr  output  AW  IFM buffer write address.
REQ-015 rd_en  output  1  IFM buffer read and weight read strobe.
REQ-016 rd_addr  output  AW  IFM read address; equals the weight column index.
REQ-017 acc_clr  output  1  clear accumulators; aligned with the first rd_en of a pass.
REQ-018 acc_en  output  1  accumulate enable, delayed RD_LAT cycles from rd_en.
REQ-019 ofm_valid  output  1  tile result available.
REQ-020 ofm_ready  input  1  downstream consumes tile result.
REQ-021 ofm_tile  output  TW  index of the current tile.
REQ-022 lane_mask  output  TILE  valid-lane mask for the current tile.
REQ-023 relu_out  output  1  latched relu_en value, forwarded to the post-processing stage.
REQ-024 busy  output  1  high in every state except IDLE.
REQ-025 done  output  1  one-cycle pulse at layer end.

Function
REQ-026 SHALL implement the states IDLE, LOAD, COMPUTE, DRAIN, OUT and DONE, held in a registered state variable.
REQ-027 IDLE: start=1 -> LOAD; counters cleared, relu_en latched.
REQ-028 LOAD: ifm_ready=1; ifm_wr_en = ifm_valid & ifm_ready, the only combinational input-to-output path; ifm_wr_addr = load counter; counter increments per accepted word; gaps in ifm_valid stall with no write.
REQ-029 LOAD -> COMPUTE on the accepted word at address IFM_SIZE-1.
REQ-030 COMPUTE: rd_en=1 every cycle; rd_addr steps 0..IFM_SIZE-1 over exactly IFM_SIZE cycles; acc_clr=1 only at rd_addr 0; after address IFM_SIZE-1 -> DRAIN.
REQ-031 acc_en SHALL be rd_en delayed by exactly RD_LAT cycles through a shift register.
REQ-032 DRAIN: lasts exactly RD_LAT cycles; rd_en=0; then -> OUT.
REQ-033 OUT: ofm_valid=1, held with ofm_tile and lane_mask stable until ofm_ready=1.
REQ-034 On the OUT handshake: if ofm_tile==NT-1 -> DONE; else ofm_tile+1 and -> COMPUTE.
REQ-035 IFM SHALL be loaded once per layer and reused by all NT passes.
REQ-036 lane_mask SHALL be all ones, except on tile NT-1 when OFM_SIZE mod TILE = R != 0, where only the low R bits are set.
REQ-037 DONE: done=1 for one cycle; -> IDLE unconditionally.
REQ-038 start SHALL be ignored in any state other than IDLE; ifm_valid SHALL be ignored outside LOAD, with ifm_ready=0.
REQ-039 A result SHALL only be dropped by reset; there is no timeout.
REQ-040 Counters SHALL wrap only at their stated terminal values; no counter exceeds IFM_SIZE-1 or NT-1.
REQ-041 Latency from the last LOAD word to the first ofm_valid SHALL be IFM_SIZE+RD_LAT+1 cycles.
REQ-042 Each subsequent tile SHALL present ofm_valid IFM_SIZE+RD_LAT+1 cycles after the previous OUT handshake.

Reset
REQ-043 rst=1 at a clock edge -> state IDLE, all counters 0, acc_en pipeline cleared, relu_out=0, and every output 0 except lane_mask, which is all ones.
REQ-044 Reset asserted in any state, including mid-COMPUTE or mid-OUT, SHALL abort the layer, with no done pulse.
REQ-045 After rst is released, the block SHALL need a fresh start and a full reload.

Verification
REQ-046 Use IFM_SIZE=4, OFM_SIZE=20, TILE=8, RD_LAT=2. Start at cycle 0 with back-to-back ifm_valid -> writes to addresses 0-3; rd_addr 0-3 with acc_clr at 0; acc_en two cycles later; ofm_valid at cycle 11.
REQ-047 Same configuration, ofm_ready always 1 -> ofm_tile 0,1,2 with lane_mask FF, FF, 0F; then done is pulsed once and busy falls the next cycle.
REQ-048 ifm_valid pattern 1,0,0,1,1,0,1 -> exactly 4 writes at addresses 0-3, and COMPUTE starts the cycle after the 4th write.
REQ-049 ofm_ready held 0 for 5 cycles in OUT -> ofm_valid, ofm_tile and lane_mask stay stable; the next COMPUTE starts the cycle after ofm_ready=1.
REQ-050 rst pulsed during tile 1 COMPUTE -> all outputs at reset values next cycle; no done pulse; a new start reloads from address 0.
REQ-051 OFM_SIZE=16, TILE=8 -> two tiles, both with lane_mask FF; start pulsed during LOAD has no effect.
